// File: rtl/mips_multicycle_controller_pkg.sv
// mips_pkg: shared constants for the multicycle MIPS controller.
// Opcode and funct encodings, 4-bit FSM state encodings, and ALU
// operation codes used by both the controller FSM and the ALU decoder.
// Optional feature macro: MIPS_MC_BNE_EN (enables the BNE state path).
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] AC_AND = 3'b000;
  localparam logic [2:0] AC_OR  = 3'b001;
  localparam logic [2:0] AC_ADD = 3'b010;
  localparam logic [2:0] AC_SUB = 3'b110;
  localparam logic [2:0] AC_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BEQ     = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    BNE     = 4'd12
  } state_t;

endpackage

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// mips_alu_decoder: combinational ALU control decode.
// Ports:
//   aluop      in  2  00 add, 01 sub, 10 decode funct (11 treated as add)
//   funct      in  6  instruction funct field
//   alucontrol out 3  ALU operation select
// Unrecognised funct codes fall back to add.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = AC_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = AC_ADD;
      ALUOP_SUB: alucontrol = AC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = AC_ADD;
          FN_SUB:  alucontrol = AC_SUB;
          FN_AND:  alucontrol = AC_AND;
          FN_OR:   alucontrol = AC_OR;
          FN_SLT:  alucontrol = AC_SLT;
          default: alucontrol = AC_ADD;
        endcase
      end
      default: alucontrol = AC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: Moore FSM control unit for the multicycle
// MIPS datapath with a unified instruction/data memory.
// Ports:
//   clk, reset (sync, active-high)
//   op, funct       instruction fields from the IR
//   zero            ALU zero flag, used in BEQ/BNE
//   pcen, memwrite, irwrite, regwrite   enables (forced 0 while reset is high)
//   iord, memtoreg, regdst, alusrca, alusrcb, pcsrc   datapath mux selects
//   alucontrol      ALU operation
//   state_o         current state encoding
// Optional feature macro: MIPS_MC_BNE_EN adds a BNE state (branch on ~zero).
//
// state   | meaning
// --------+---------------------------------------------
// FETCH   | read instr at PC into IR, PC <= PC + 4
// DECODE  | compute branch target into ALUOut, dispatch on op
// MEMADR  | ALUOut <= A + SignImm (lw/sw address)
// MEMRD   | read data memory at ALUOut
// MEMWB   | rt <= Data
// MEMWR   | write B to memory at ALUOut
// EXECUTE | R-type ALU operation
// ALUWB   | rd <= ALUOut
// BEQ     | compare A, B; PC <= ALUOut if equal
// ADDIEX  | ALUOut <= A + SignImm
// ADDIWB  | rt <= ALUOut
// JUMP    | PC <= jump target
// BNE     | compare A, B; PC <= ALUOut if not equal (optional)
module mips_multicycle_controller
  import mips_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6,
  parameter int ACW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  output logic           pcen,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regwrite,
  output logic           iord,
  output logic           memtoreg,
  output logic           regdst,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [ACW-1:0] alucontrol,
  output logic [3:0]     state_o
);

  state_t     state, state_nxt;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;
  logic       bne_branch;
  logic       memwrite_raw;
  logic       irwrite_raw;
  logic       regwrite_raw;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXECUTE;
          OP_BEQ:       state_nxt = BEQ;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JUMP;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_nxt = BNE;
`endif
          default:      state_nxt = FETCH;
        endcase
      end
      MEMADR:  state_nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_nxt = MEMWB;
      EXECUTE: state_nxt = ALUWB;
      ADDIEX:  state_nxt = ADDIWB;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    bne_branch   = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = ALUOP_ADD;
    case (state)
      FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      BEQ: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIWB: regwrite_raw = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MIPS_MC_BNE_EN
      BNE: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        pcsrc      = 2'b01;
        bne_branch = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Enables are gated by reset directly so an instruction interrupted by
  // reset cannot complete a write in the cycle reset is first seen.
  assign pcen     = ~reset & (pcwrite | (branch & zero) | (bne_branch & ~zero));
  assign memwrite = ~reset & memwrite_raw;
  assign irwrite  = ~reset & irwrite_raw;
  assign regwrite = ~reset & regwrite_raw;
  assign state_o  = state;

  mips_alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct[5:0]),
    .alucontrol (alucontrol)
  );

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
Control unit for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback over multiple cycles through a Moore FSM. It drives the mux selects, write enables and ALU control of the shared datapath and unified memory. It sits inside the multicycle top, alongside the datapath, and replaces the single-cycle combinational decoder.

Parameters:
- OPW, 6, opcode field width (instr[31:26])
- FNW, 6, funct field width (instr[5:0])
- ACW, 3, ALU control width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  opcode from instruction register
- funct  in  6  funct from instruction register
- zero  in  1  ALU zero flag, valid in the BEQ/BNE state
- pcen  out  1  PC register enable
- memwrite  out  1  unified memory write enable
- irwrite  out  1  instruction register enable
- regwrite  out  1  register file write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  out  1  write-back select: 0 = ALUOut, 1 = Data
- regdst  out  1  destination register: 0 = rt, 1 = rd
- alusrca  out  1  ALU A: 0 = PC, 1 = A reg
- alusrcb  out  2  ALU B: 00 = B reg, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt
- state_o  out  4  current state encoding (debug/verification)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset entry: reset high at a rising edge -> state = FETCH.
- Reset gating: while reset is high, pcen, irwrite, memwrite and regwrite are forced to 0, independent of state. Reset mid-instruction abandons the instruction; no partial write occurs after that edge.
- Output timing: Moore outputs decoded from state only, except pcen = pcwrite | (branch & zero). All outputs not listed for a state are 0.
- aluop: 2-bit aluop from the FSM feeds the ALU decoder. 00 -> add; 01 -> sub; 10 -> decode funct.
- funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct -> add (010).
- States and outputs:
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1 -> DECODE.
  - DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by op:
    - lw 100011 / sw 101011 -> MEMADR
    - R-type 000000 -> EXECUTE
    - beq 000100 -> BEQ
    - addi 001000 -> ADDIEX
    - j 000010 -> JUMP
    - any other op -> FETCH (treated as NOP, no writes)
  - MEMADR: alusrca=1, alusrcb=10, aluop=00 -> MEMRD if lw, else MEMWR.
  - MEMRD: iord=1 -> MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
  - MEMWR: iord=1, memwrite=1 -> FETCH.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
  - BEQ: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
  - JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
- Write exclusivity: at most one of memwrite/regwrite is asserted in any cycle. irwrite is asserted only in FETCH.

Optional Feature:
- Macro: MIPS_MC_BNE_EN.
- Defined: op 000101 -> BNE state in DECODE. BNE is identical to BEQ, but pcen = pcwrite | (bne_branch & ~zero). 3 cycles.
- Undefined: op 000101 falls to the unknown-op path (DECODE -> FETCH, no writes), and the BNE encoding is unused.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - funct constants
  - 4-bit state encodings (FETCH=0 … JUMP=11, BNE=12)
  - aluop and alucontrol constants
- One sub-module: mips_alu_decoder. Purely combinational; takes aluop and funct, produces alucontrol. The FSM and output decode stay in the top controller.

Test Plan:
- Reset held 2 cycles mid-MEMWR (op=101011) -> memwrite=0 throughout. State_o=FETCH after release. First cycle: irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- op=100011 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. regwrite=1 with memtoreg=1 and regdst=0 only in the 5th cycle. iord=1 in cycle 4.
- op=000000 with funct 100010, then funct 101010 -> alucontrol=110, then 111, in EXECUTE. ALUWB: regdst=1, regwrite=1. CPI=4.
- op=000100 with zero=1 -> pcen=1 and pcsrc=01 in BEQ. Repeat with zero=0 -> pcen=0. Next state FETCH in both cases.
- op=000010 -> JUMP, pcen=1, pcsrc=10. op=111111 -> DECODE->FETCH with all write enables 0.
- With MIPS_MC_BNE_EN: op=000101, zero=0 -> pcen=1. With zero=1 -> pcen=0. Without the macro -> state_o goes from DECODE back to FETCH.
